// File: rtl/alsu_checker.sv
// Self-checking monitor for the ALSU: snoops the ALSU input bundle, runs a golden
// model with the same two-cycle latency and scores the ALSU out/leds against it.
module alsu_checker #(
  parameter string INPUT_PRIORITY = "A",
  parameter string FULL_ADDER     = "ON",
  parameter int    CNT_W          = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             check_en,
  input  logic [2:0]       A,
  input  logic [2:0]       B,
  input  logic [2:0]       opcode,
  input  logic             cin,
  input  logic             serial_in,
  input  logic             direction,
  input  logic             red_op_A,
  input  logic             red_op_B,
  input  logic             bypass_A,
  input  logic             bypass_B,
  input  logic [5:0]       dut_out,
  input  logic [15:0]      dut_leds,
  output logic [5:0]       exp_out,
  output logic             mismatch,
  output logic             error,
  output logic [CNT_W-1:0] pass_cnt,
  output logic [CNT_W-1:0] fail_cnt,
  output logic [2:0]       first_fail_opcode,
  output logic [5:0]       first_fail_out
);

  typedef enum logic [1:0] {ADD_FULL, ADD_HALF, ADD_ZERO} add_mode_e;

  localparam bit        PRIO_B   = (INPUT_PRIORITY == "B");
  localparam add_mode_e ADD_MODE = (FULL_ADDER == "ON")  ? ADD_FULL :
                                   (FULL_ADDER == "OFF") ? ADD_HALF : ADD_ZERO;

  localparam logic [2:0] OP_AND   = 3'd0;
  localparam logic [2:0] OP_XOR   = 3'd1;
  localparam logic [2:0] OP_ADD   = 3'd2;
  localparam logic [2:0] OP_MUL   = 3'd3;
  localparam logic [2:0] OP_SHIFT = 3'd4;
  localparam logic [2:0] OP_ROT   = 3'd5;

  typedef struct packed {
    logic [2:0] a;
    logic [2:0] b;
    logic [2:0] opcode;
    logic       cin;
    logic       serial_in;
    logic       direction;
    logic       red_a;
    logic       red_b;
    logic       byp_a;
    logic       byp_b;
  } bundle_t;

  bundle_t          s1_q;
  logic             v1_q;
  logic [5:0]       exp_out_q, exp_out_d;
  logic [15:0]      exp_leds_q, exp_leds_d;
  logic [2:0]       op2_q;
  logic             v2_q;

  logic [CNT_W-1:0] pass_cnt_q, pass_cnt_d;
  logic [CNT_W-1:0] fail_cnt_q, fail_cnt_d;
  logic             mismatch_q, mismatch_d;
  logic             error_q, error_d;
  logic [2:0]       ff_op_q, ff_op_d;
  logic [5:0]       ff_out_q, ff_out_d;

  // Stage 1: capture the bundle exactly as the ALSU registers it.
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of block ordering.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1_q <= '0;
      v1_q <= 1'b0;
    end else begin
      s1_q <= '{a: A, b: B, opcode: opcode, cin: cin, serial_in: serial_in,
                direction: direction, red_a: red_op_A, red_b: red_op_B,
                byp_a: bypass_A, byp_b: bypass_B};
      v1_q <= check_en;
    end
  end

  logic [2:0] pri_op;
  logic [2:0] red_src;
  logic       use_red;
  logic       invalid;
  logic [3:0] sum4;

  // Golden model; history terms read exp_out_q, never dut_out.
  // NOTE: every always_comb output gets a default first so no path infers a latch.
  always_comb begin
    pri_op     = PRIO_B ? s1_q.b : s1_q.a;
    use_red    = s1_q.red_a | s1_q.red_b;
    red_src    = (s1_q.red_a && s1_q.red_b) ? pri_op : (s1_q.red_a ? s1_q.a : s1_q.b);
    invalid    = (s1_q.opcode inside {3'd6, 3'd7}) ||
                 (use_red && !(s1_q.opcode inside {OP_AND, OP_XOR}));
    sum4       = '0;
    exp_out_d  = '0;
    exp_leds_d = '0;

    if (ADD_MODE == ADD_FULL) begin
      sum4 = {1'b0, s1_q.a} + {1'b0, s1_q.b} + {3'b000, s1_q.cin};
    end else if (ADD_MODE == ADD_HALF) begin
      sum4 = {1'b0, s1_q.a} + {1'b0, s1_q.b};
    end

    if (s1_q.byp_a || s1_q.byp_b) begin
      if (s1_q.byp_a && s1_q.byp_b) exp_out_d = {3'b000, pri_op};
      else if (s1_q.byp_a)          exp_out_d = {3'b000, s1_q.a};
      else                          exp_out_d = {3'b000, s1_q.b};
    end else if (invalid) begin
      exp_leds_d = ~exp_leds_q;
    end else begin
      case (s1_q.opcode)
        OP_AND:   exp_out_d = use_red ? {5'b0, &red_src} : {3'b000, s1_q.a & s1_q.b};
        OP_XOR:   exp_out_d = use_red ? {5'b0, ^red_src} : {3'b000, s1_q.a ^ s1_q.b};
        OP_ADD:   exp_out_d = {2'b00, sum4};
        OP_MUL:   exp_out_d = {3'b000, s1_q.a} * {3'b000, s1_q.b};
        OP_SHIFT: exp_out_d = s1_q.direction ? {exp_out_q[4:0], s1_q.serial_in}
                                             : {s1_q.serial_in, exp_out_q[5:1]};
        OP_ROT:   exp_out_d = s1_q.direction ? {exp_out_q[4:0], exp_out_q[5]}
                                             : {exp_out_q[0], exp_out_q[5:1]};
        default:  exp_out_d = '0;
      endcase
    end
  end

  // Stage 2: the model free-runs every cycle, like the ALSU it shadows.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      exp_out_q  <= '0;
      exp_leds_q <= '0;
      op2_q      <= '0;
      v2_q       <= 1'b0;
    end else begin
      exp_out_q  <= exp_out_d;
      exp_leds_q <= exp_leds_d;
      op2_q      <= s1_q.opcode;
      v2_q       <= v1_q;
    end
  end

  logic match;
  assign match = (dut_out == exp_out_q) && (dut_leds == exp_leds_q);

  always_comb begin
    pass_cnt_d = pass_cnt_q;
    fail_cnt_d = fail_cnt_q;
    mismatch_d = 1'b0;
    error_d    = error_q;
    ff_op_d    = ff_op_q;
    ff_out_d   = ff_out_q;
    if (v2_q) begin
      if (match) begin
        if (pass_cnt_q != '1) pass_cnt_d = pass_cnt_q + CNT_W'(1);
      end else begin
        if (fail_cnt_q != '1) fail_cnt_d = fail_cnt_q + CNT_W'(1);
        mismatch_d = 1'b1;
        error_d    = 1'b1;
        // Only the first failure is captured; later ones leave it intact.
        if (!error_q) begin
          ff_op_d  = op2_q;
          ff_out_d = dut_out;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pass_cnt_q <= '0;
      fail_cnt_q <= '0;
      mismatch_q <= 1'b0;
      error_q    <= 1'b0;
      ff_op_q    <= '0;
      ff_out_q   <= '0;
    end else begin
      pass_cnt_q <= pass_cnt_d;
      fail_cnt_q <= fail_cnt_d;
      mismatch_q <= mismatch_d;
      error_q    <= error_d;
      ff_op_q    <= ff_op_d;
      ff_out_q   <= ff_out_d;
    end
  end

  assign exp_out           = exp_out_q;
  assign mismatch          = mismatch_q;
  assign error             = error_q;
  assign pass_cnt          = pass_cnt_q;
  assign fail_cnt          = fail_cnt_q;
  assign first_fail_opcode = ff_op_q;
  assign first_fail_out    = ff_out_q;

endmodule
